cadu_framer: RTL
================

CADU_FRAMER -- requirements
Module: cadu_framer

Interface
REQ-001 SHALL have parameter BITS_PER_FRAME, default 8192; CADU length in bits, including the ASM.
REQ-002 SHALL have parameter ASM_WORD, default 32'h1ACFFC1D; attached sync marker.
REQ-003 SHALL have parameter MAX_ASM_ERR, default 4; maximum Hamming distance for an ASM to count as good.
REQ-004 SHALL have parameter LOSS_THRESH, default 3; consecutive bad ASMs that drop lock.
REQ-005 SHALL have port clk, input, 1 bit; the single clock, all logic on its rising edge.
REQ-006 SHALL have port rst_in, input, 1 bit; reset, asynchronous, active-low.
REQ-007 SHALL have port hard_inp, input, 1 bit; hard-decision bit, same stream presented to uw_cadu.
REQ-008 SHALL have port valid_in, input, 1 bit; qualifies hard_inp.
REQ-009 SHALL have port offset_valid, input, 1 bit; one-cycle pulse carrying the uw_cadu result.
REQ-010 SHALL have port bit_offset, input, $clog2(BITS_PER_FRAME) bits; bit position of the first ASM bit.
REQ-011 SHALL have port ready_rx, output, 1 bit; high when the framer accepts a new offset.
REQ-012 SHALL have port byte_out, output, 8 bits; payload byte, MSB = first received bit.
REQ-013 SHALL have port byte_valid, output, 1 bit; one-cycle strobe for byte_out.
REQ-014 SHALL have port frame_start, output, 1 bit; asserted with the first payload byte of a frame.
REQ-015 SHALL have port frame_end, output, 1 bit; asserted with the last payload byte of a frame.
REQ-016 SHALL have port locked, output, 1 bit; high while the framer is tracking frames.
REQ-017 SHALL have port lock_lost, output, 1 bit; one-cycle pulse when lock drops.
REQ-018 SHALL have port asm_dist, output, 6 bits; Hamming distance of the most recent ASM.
REQ-019 SHALL have port frame_count, output, 16 bits; number of frames emitted, wraps modulo 2^16.

Function
REQ-020 SHALL implement states IDLE, SKIP, ASM, PAYLOAD.
REQ-021 IDLE: ready_rx=1; on offset_valid SHALL latch bit_offset and go to SKIP, or directly to ASM if bit_offset=0.
REQ-022 SKIP: SHALL discard exactly bit_offset valid bits, then enter ASM.
REQ-023 Bit counting: bits with valid_in=0 SHALL be ignored and every counter SHALL hold.
REQ-024 ASM: SHALL shift in 32 bits; on the 32nd bit, compare against ASM_WORD via asm_compare and register asm_dist the next cycle.
REQ-025 Good ASM (dist<=MAX_ASM_ERR): SHALL clear the bad counter, set locked=1, and enter PAYLOAD.
REQ-026 Bad ASM, bad counter+1 < LOSS_THRESH: SHALL increment the bad counter and enter PAYLOAD, flywheeling with no realignment.
REQ-027 Bad ASM, bad counter+1 = LOSS_THRESH: SHALL pulse lock_lost, clear locked, discard the frame, and return to IDLE.
REQ-028 A bad first ASM after IDLE: SHALL return to IDLE with no lock_lost pulse.
REQ-029 PAYLOAD: SHALL pack (BITS_PER_FRAME-32)/8 bytes, default 1020.
REQ-030 Byte output: byte_valid SHALL pulse the cycle after the 8th bit of each byte is accepted.
REQ-031 After the last payload bit, SHALL increment frame_count and return to ASM.
REQ-032 offset_valid outside IDLE SHALL be ignored.
REQ-033 byte_valid SHALL never assert in IDLE, SKIP or ASM.
REQ-034 Outputs SHALL be registered.

Reset
REQ-035 While rst_in=0, the following SHALL be forced:
- state=IDLE, ready_rx=1 (REQ-021);
- all counters and the shift register = 0;
- byte_out=0, byte_valid=0, frame_start=0, frame_end=0;
- locked=0, lock_lost=0, asm_dist=0, frame_count=0.
REQ-036 Reset mid-frame SHALL abandon the partial byte and frame, with no frame_end emitted.

Structure
REQ-037 The shared package SHALL hold ASM_WORD, the state enum type and the CADU byte-count constant; uw_cadu SHALL use the same ASM_WORD.
REQ-038 SHALL contain one sub-module, asm_compare: combinational 32-bit XOR and popcount, producing a 6-bit distance.

Verification
REQ-039 Offset 0, 4 clean frames with payload byte k = k mod 256 SHALL give:
- 4080 byte_valid pulses, bytes matching the payload;
- frame_start and frame_end 4 times each;
- frame_count=4, locked=1, asm_dist=0.
REQ-040 Offset 37 with random prefix bits SHALL give a first byte equal to payload byte 0 and frame_count=1 after one frame.
REQ-041 3 flipped bits in the ASM of frame 2 SHALL give asm_dist=3, locked=1, and unchanged payload output.
REQ-042 ASMs of frames 2-4 each with 8 flipped bits SHALL give:
- frames 2-3 still emitted;
- lock_lost pulse at the frame-4 ASM;
- locked=0, ready_rx=1, and no frame-4 bytes.
REQ-043 valid_in toggled 50% randomly SHALL give byte output identical to the continuous-valid case.
REQ-044 rst_in low for one cycle at payload byte 500 SHALL give all outputs at reset values immediately; a new offset_valid then relocks.

Source files
------------

// File: rtl/cadu_framer_pkg.sv
// cadu_framer_pkg: attached sync marker, framer state type and CADU sizing,
// shared by cadu_framer and uw_cadu so both search for the same marker.
package cadu_framer_pkg;
  localparam logic [31:0] ASM_WORD = 32'h1ACFFC1D;
  localparam int CADU_BITS = 8192;
  localparam int CADU_BYTES = (CADU_BITS - 32) / 8;
  typedef enum logic [1:0] {IDLE, SKIP, ASM, PAYLOAD} state_e;
endpackage

// File: rtl/asm_compare.sv
// asm_compare: Hamming distance between a received 32-bit word and the sync marker.
module asm_compare (
  input  logic [31:0] word_i,
  input  logic [31:0] ref_i,
  output logic [5:0]  dist_o
);
  assign dist_o = 6'($countones(word_i ^ ref_i));
endmodule

// File: rtl/cadu_framer.sv
// cadu_framer: aligns to the offset from uw_cadu, checks each ASM with a
// flywheel loss counter and emits the CADU payload as bytes.
module cadu_framer
  import cadu_framer_pkg::*;
#(
  parameter int          BITS_PER_FRAME = CADU_BITS,
  parameter logic [31:0] ASM_WORD       = cadu_framer_pkg::ASM_WORD,
  parameter int          MAX_ASM_ERR    = 4,
  parameter int          LOSS_THRESH    = 3
) (
  input  logic                              clk,
  input  logic                              rst_in,
  input  logic                              hard_inp,
  input  logic                              valid_in,
  input  logic                              offset_valid,
  input  logic [$clog2(BITS_PER_FRAME)-1:0] bit_offset,
  output logic                              ready_rx,
  output logic [7:0]                        byte_out,
  output logic                              byte_valid,
  output logic                              frame_start,
  output logic                              frame_end,
  output logic                              locked,
  output logic                              lock_lost,
  output logic [5:0]                        asm_dist,
  output logic [15:0]                       frame_count
);
  localparam int CW = $clog2(BITS_PER_FRAME);
  localparam logic [CW-1:0] PAY_LAST = CW'(BITS_PER_FRAME - 33);
  state_e state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d, off_q, off_d;
  logic [31:0] sr_q, sr_d;
  logic [7:0] bad_q, bad_d, byte_q, byte_d;
  logic [5:0] dist_q, dist_d, dist_c;
  logic [15:0] fc_q, fc_d;
  logic first_q, first_d, rdy_q, rdy_d, bv_q, bv_d, fs_q, fs_d, fe_q, fe_d;
  logic lk_q, lk_d, ll_q, ll_d, good;
  // The shifter runs on every accepted bit; only the FSM decides what it means.
  assign sr_d = valid_in ? {sr_q[30:0], hard_inp} : sr_q;
  asm_compare u_cmp (.word_i(sr_d), .ref_i(ASM_WORD), .dist_o(dist_c));
  assign good = dist_c <= 6'(MAX_ASM_ERR);
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    off_d   = off_q;
    bad_d   = bad_q;
    first_d = first_q;
    byte_d  = byte_q;
    dist_d  = dist_q;
    fc_d    = fc_q;
    lk_d    = lk_q;
    bv_d    = 1'b0;
    fs_d    = 1'b0;
    fe_d    = 1'b0;
    ll_d    = 1'b0;
    case (state_q)
      IDLE: if (offset_valid) begin
        off_d   = bit_offset;
        cnt_d   = '0;
        first_d = 1'b1;
        state_d = bit_offset == '0 ? ASM : SKIP;
      end
      SKIP: if (valid_in) begin
        cnt_d   = cnt_q == off_q - CW'(1) ? '0 : cnt_q + CW'(1);
        state_d = cnt_q == off_q - CW'(1) ? ASM : SKIP;
      end
      ASM: if (valid_in) begin
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(31)) begin
          cnt_d  = '0;
          dist_d = dist_c;
          if (good) begin
            bad_d   = '0;
            lk_d    = 1'b1;
            first_d = 1'b0;
            state_d = PAYLOAD;
          end else if (first_q) begin
            state_d = IDLE;
          end else if (bad_q + 8'd1 < 8'(LOSS_THRESH)) begin
            bad_d   = bad_q + 8'd1;
            state_d = PAYLOAD;
          end else begin
            bad_d   = '0;
            lk_d    = 1'b0;
            ll_d    = 1'b1;
            state_d = IDLE;
          end
        end
      end
      PAYLOAD: if (valid_in) begin
        cnt_d = cnt_q == PAY_LAST ? '0 : cnt_q + CW'(1);
        if (cnt_q[2:0] == 3'd7) begin
          byte_d = sr_d[7:0];
          bv_d   = 1'b1;
          fs_d   = cnt_q == CW'(7);
          fe_d   = cnt_q == PAY_LAST;
        end
        if (cnt_q == PAY_LAST) begin
          fc_d    = fc_q + 16'd1;
          state_d = ASM;
        end
      end
    endcase
    rdy_d = state_d == IDLE;
  end
  always_ff @(posedge clk or negedge rst_in) begin
    if (!rst_in) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      off_q   <= '0;
      sr_q    <= '0;
      bad_q   <= '0;
      byte_q  <= '0;
      dist_q  <= '0;
      fc_q    <= '0;
      first_q <= 1'b0;
      rdy_q   <= 1'b1;
      bv_q    <= 1'b0;
      fs_q    <= 1'b0;
      fe_q    <= 1'b0;
      lk_q    <= 1'b0;
      ll_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      off_q   <= off_d;
      sr_q    <= sr_d;
      bad_q   <= bad_d;
      byte_q  <= byte_d;
      dist_q  <= dist_d;
      fc_q    <= fc_d;
      first_q <= first_d;
      rdy_q   <= rdy_d;
      bv_q    <= bv_d;
      fs_q    <= fs_d;
      fe_q    <= fe_d;
      lk_q    <= lk_d;
      ll_q    <= ll_d;
    end
  end
  assign ready_rx    = rdy_q;
  assign byte_out    = byte_q;
  assign byte_valid  = bv_q;
  assign frame_start = fs_q;
  assign frame_end   = fe_q;
  assign locked      = lk_q;
  assign lock_lost   = ll_q;
  assign asm_dist    = dist_q;
  assign frame_count = fc_q;
endmodule
